// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Sequencing front-end for the 4-bit ALU. Operation requests are buffered in
// a small FIFO, then issued one at a time by driving the ALU operand and
// opcode registers for a single enabled cycle. The combinational ALU result
// is captured into a response register that is offered downstream over a
// valid/ready handshake.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   REQ_VALID/READY     request handshake (READY = FIFO not full)
//   REQ_A/B/OP          request operands and opcode (00 ADD, 01 SUB, 10 AND, 11 OR)
//   ALU_A/B/OP          registered operands/opcode driven to the ALU
//   ALU_EN              ALU master enable, high only in the execute cycle
//   ALU_RES/ALU_CB      ALU result and carry/borrow (combinational inputs)
//   RSP_VALID/READY     response handshake
//   RSP_RES/CB/ZERO/OP  captured result, carry/borrow, zero flag, opcode
//   OP_COUNT            completed responses, wraps
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [3:0]       REQ_A,
   input  logic [3:0]       REQ_B,
   input  logic [1:0]       REQ_OP,
   output logic [3:0]       ALU_A,
   output logic [3:0]       ALU_B,
   output logic [1:0]       ALU_OP,
   output logic             ALU_EN,
   input  logic [3:0]       ALU_RES,
   input  logic             ALU_CB,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [3:0]       RSP_RES,
   output logic             RSP_CB,
   output logic             RSP_ZERO,
   output logic [1:0]       RSP_OP,
   output logic [CNT_W-1:0] OP_COUNT
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_FW = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;

   // FIFO storage: {A[3:0], B[3:0], OP[1:0]}
   logic [9:0]          mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_FW-1:0]   count_q;

   logic [3:0]          alu_a_q, alu_b_q;
   logic [1:0]          alu_op_q;
   logic [3:0]          rsp_res_q;
   logic                rsp_cb_q, rsp_zero_q;
   logic [1:0]          rsp_op_q;
   logic [CNT_W-1:0]    op_cnt_q;

   logic                push, pop, capture, rsp_hs;
   logic                alu_en, rsp_valid;
   logic                fifo_empty;
   logic [9:0]          head;

   // Ready comes only from the registered count: a full FIFO refuses a push
   // even when the FSM pops in the same cycle.
   assign REQ_READY  = (count_q != CNT_FW'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = REQ_VALID && REQ_READY;
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      capture   = 1'b0;
      rsp_hs    = 1'b0;
      alu_en    = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_en  = 1'b1;
            capture = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (RSP_READY) begin
               rsp_hs = 1'b1;
               // Chain straight into the next operation to sustain one
               // response every two cycles.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rsp_res_q  <= '0;
         rsp_cb_q   <= 1'b0;
         rsp_zero_q <= 1'b0;
         rsp_op_q   <= '0;
         op_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_FW'(1);
            2'b01:   count_q <= count_q - CNT_FW'(1);
            default: count_q <= count_q;
         endcase
         if (pop) begin
            alu_a_q  <= head[9:6];
            alu_b_q  <= head[5:2];
            alu_op_q <= head[1:0];
         end
         if (capture) begin
            rsp_res_q  <= ALU_RES;
            rsp_cb_q   <= ALU_CB;
            rsp_zero_q <= (ALU_RES == 4'h0);
            rsp_op_q   <= alu_op_q;
         end
         if (rsp_hs) op_cnt_q <= op_cnt_q + CNT_W'(1);
      end
   end

   // Entry storage carries no reset; occupancy is governed by the pointers.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {REQ_A, REQ_B, REQ_OP};
   end

   assign ALU_A     = alu_a_q;
   assign ALU_B     = alu_b_q;
   assign ALU_OP    = alu_op_q;
   assign ALU_EN    = alu_en;
   assign RSP_VALID = rsp_valid;
   assign RSP_RES   = rsp_res_q;
   assign RSP_CB    = rsp_cb_q;
   assign RSP_ZERO  = rsp_zero_q;
   assign RSP_OP    = rsp_op_q;
   assign OP_COUNT  = op_cnt_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing front-end for the 4-bit ALU. It accepts operation requests (operands plus opcode) over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the downstream ALU by driving its A/B/ALU_CONT/EN inputs, then captures ALU_OUT/CARRY_BORROW into a response register offered over a second valid/ready handshake. It sits directly upstream of the ALU and also consumes its combinational result.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- CNT_W, 8, width of completed-operation counter

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  FIFO can accept (= not full)
- REQ_A  in  4  operand A
- REQ_B  in  4  operand B
- REQ_OP  in  2  00=ADD, 01=SUB, 10=AND, 11=OR
- ALU_A  out  4  registered operand to ALU A
- ALU_B  out  4  registered operand to ALU B
- ALU_OP  out  2  registered opcode to ALU_CONT
- ALU_EN  out  1  ALU master enable
- ALU_RES  in  4  ALU_OUT from ALU (combinational)
- ALU_CB  in  1  CARRY_BORROW from ALU
- RSP_VALID  out  1  response held
- RSP_READY  in  1  consumer accepts response
- RSP_RES  out  4  captured result
- RSP_CB  out  1  captured carry/borrow (0 for AND/OR)
- RSP_ZERO  out  1  captured result == 0
- RSP_OP  out  2  opcode of captured result
- OP_COUNT  out  CNT_W  completed responses, wraps

## Operation
- FIFO: push on REQ_VALID && REQ_READY. Pop only under FSM control. Stores {A,B,OP}. Occupancy counter runs 0..DEPTH. REQ_READY = (count != DEPTH), combinational from registered count.
- Push and pop on the same edge: count unchanged, both take effect.
- When full, REQ_READY=0 even if a pop occurs that cycle (no bypass).
- FSM states:
  - IDLE: if FIFO non-empty, pop head into ALU_A/ALU_B/ALU_OP and go to EXEC. Else stay.
  - EXEC: ALU_EN=1 for exactly this cycle. At edge, capture ALU_RES→RSP_RES, ALU_CB→RSP_CB, (ALU_RES==0)→RSP_ZERO, ALU_OP→RSP_OP, and go to RESP.
  - RESP: RSP_VALID=1. On RSP_VALID && RSP_READY: OP_COUNT+1. If FIFO non-empty, pop the next entry into the ALU operand registers and go to EXEC; else go to IDLE. Without RSP_READY, hold every RSP_* output stable.
- ALU_EN=0 in IDLE and RESP. ALU_A/B/OP keep the last issued values outside EXEC (not cleared).
- RSP_CB is taken from ALU_CB as-is. The ALU returns 0 for opcodes 10/11, and the bench checks that.
- OP_COUNT wraps (2^CNT_W−1)+1 → 0. There is no saturation.
- Requests complete strictly in FIFO order. There is no reordering or drop.

## Timing
- Reset values: state=IDLE, FIFO empty (count=0, pointers=0), REQ_READY=1, ALU_A=0, ALU_B=0, ALU_OP=00, ALU_EN=0, RSP_VALID=0, RSP_RES=0, RSP_CB=0, RSP_ZERO=0, RSP_OP=00, OP_COUNT=0.
- RST asserted mid-operation: at the next edge everything returns to reset values. FIFO contents and any pending response are discarded.
- Latency, request accepted at edge k into an idle, empty block:
  - popped at edge k+1
  - ALU_EN high in cycle k+1..k+2
  - captured at edge k+2
  - RSP_VALID high from edge k+2
- A push into an empty FIFO is not visible to the FSM until the following cycle. There is no same-cycle bypass.
- Back-to-back throughput is one response per 2 cycles (RESP→EXEC→RESP) with RSP_READY held high.
- RSP_READY asserted in the same cycle RSP_VALID rises completes the handshake at the next edge.

## Test plan
- Reset/idle: hold RST 2 cycles, then release → all outputs at reset values, REQ_READY=1, ALU_EN never pulses with FIFO empty.
- Single ADD: A=9, B=8, OP=00, RSP_READY=1 → ALU_EN high exactly one cycle at k+1. RSP_VALID at k+2 with RSP_RES=1, RSP_CB=1, RSP_ZERO=0. OP_COUNT=1.
- Stream of 4 ops (ADD 3+4, SUB 2−5, AND F&0, OR A|5) with RSP_READY=1 → responses in order: 7/CB0; D/CB1; 0/CB0/ZERO1; F/CB0. RSP_VALID is asserted every other cycle.
- Backpressure: RSP_READY=0, push 6 requests → REQ_READY drops after DEPTH+1 acceptances (4 in the FIFO, 1 in RESP). RSP_* stable while stalled. Releasing RSP_READY drains all entries in order.
- Push/pop on the same edge with the FIFO at count=2 → count stays 2, no entry lost or duplicated.
- Mid-operation reset during RESP with 3 entries queued → next cycle RSP_VALID=0, FIFO empty, OP_COUNT=0, and no further ALU_EN pulses.
- Counter wrap: CNT_W=8, complete 256 responses → OP_COUNT reads 0.
